// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion bank controller: snoops gate-array RAM-config writes and decodes SRAM bank/select.
// Optional readback of the config register via IN from the port is enabled by CPC_RAM_READBACK_EN.
module cpc_ram_bank_ctrl #(
  parameter  int BANK_BITS  = 3,
  parameter  int PORT_XBITS = 0,
  localparam int ADR_W      = 2 + BANK_BITS + PORT_XBITS,
  localparam int CFG_W      = 3 + BANK_BITS + PORT_XBITS
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [15:0]      A,
  input  logic [7:0]       D_IN,
  input  logic             IOREQ_B,
  input  logic             MREQ_B,
  input  logic             WR_B,
  input  logic             RD_B,
  input  logic             M1_B,
  output logic [ADR_W-1:0] RAMADR_HI,
  output logic             RAMCS_B,
  output logic             RAMDIS,
  output logic [CFG_W-1:0] CFG,
  output logic [7:0]       DOUT,
  output logic             DOE
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic             iorq_meta_reg, iorq_s_reg;
  logic             wr_meta_reg, wr_s_reg;
  logic             wstb;
  logic [1:0]       state_reg, state_next;
  logic [CFG_W-1:0] cfg_reg, cfg_next;
  logic [CFG_W-1:0] cfg_new;
  logic             ext;
  logic [1:0]       page;

  // Synchronisers come out of reset reading "strobe active", so a write that
  // straddles reset release keeps the FSM in HOLD until the strobe goes high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iorq_meta_reg <= 1'b0;
      iorq_s_reg    <= 1'b0;
      wr_meta_reg   <= 1'b0;
      wr_s_reg      <= 1'b0;
    end else begin
      iorq_meta_reg <= IOREQ_B;
      iorq_s_reg    <= iorq_meta_reg;
      wr_meta_reg   <= WR_B;
      wr_s_reg      <= wr_meta_reg;
    end
  end

  assign wstb = ~iorq_s_reg & ~wr_s_reg;

  generate
    if (PORT_XBITS > 0) begin : g_xbank
      assign cfg_new = {~A[8+PORT_XBITS-1:8], D_IN[5:0]};
    end else begin : g_no_xbank
      assign cfg_new = D_IN[5:0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cfg_next   = cfg_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wstb) begin
          if (!A[15] && D_IN[7:6] == 2'b11) state_next = ST_CAPTURE;
          else                              state_next = ST_HOLD;
        end
      end
      ST_CAPTURE: begin
        cfg_next   = cfg_new;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!wstb) state_next = ST_IDLE;
      end
      default: state_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_HOLD;
      cfg_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cfg_reg   <= cfg_next;
    end
  end

  // Address decode: which 16K quarter goes to expansion RAM, and which page of the bank.
  always_comb begin
    ext  = 1'b0;
    page = A[15:14];
    case (cfg_reg[2:0])
      3'd0: ext = 1'b0;
      3'd1, 3'd3: begin
        ext  = (A[15:14] == 2'b11);
        page = 2'b11;
      end
      3'd2: ext = 1'b1;
      default: begin
        ext  = (A[15:14] == 2'b01);
        page = cfg_reg[1:0];
      end
    endcase
  end

  assign RAMADR_HI = ext ? {cfg_reg[CFG_W-1:3], page} : '0;
  assign RAMDIS    = ext;
  assign RAMCS_B   = ~(ext & ~MREQ_B);
  assign CFG       = cfg_reg;

`ifdef CPC_RAM_READBACK_EN
  // Combinational so the data is on the bus in time for the Z80 T3 sample.
  assign DOE  = ~IOREQ_B & ~RD_B & M1_B & ~A[15];
  assign DOUT = DOE ? {2'b11, cfg_reg[5:0]} : 8'h00;
`else
  assign DOE  = 1'b0;
  assign DOUT = 8'h00;
`endif

  logic unused_bits;
  assign unused_bits = ^{A[13:0], RD_B, M1_B};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Scoreboard bench for cpc_ram_bank_ctrl (PORT_XBITS=3): directed bus cycles plus random traffic.
module tb_cpc_ram_bank_ctrl;

  localparam int XB    = 3;
  localparam int ADR_W = 5 + XB;
  localparam int CFG_W = 6 + XB;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      a;
  logic [7:0]       d_in;
  logic             iorq_b, mreq_b, wr_b, rd_b, m1_b;
  logic [ADR_W-1:0] ramadr_hi;
  logic             ramcs_b, ramdis, doe;
  logic [CFG_W-1:0] cfg;
  logic [7:0]       dout;

  cpc_ram_bank_ctrl #(.BANK_BITS(3), .PORT_XBITS(XB)) dut (
    .CLK(clk), .RESET(rst), .A(a), .D_IN(d_in),
    .IOREQ_B(iorq_b), .MREQ_B(mreq_b), .WR_B(wr_b), .RD_B(rd_b), .M1_B(m1_b),
    .RAMADR_HI(ramadr_hi), .RAMCS_B(ramcs_b), .RAMDIS(ramdis),
    .CFG(cfg), .DOUT(dout), .DOE(doe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic             cs_b;
    logic             dis;
    logic [ADR_W-1:0] adr;
    logic [CFG_W-1:0] cfg;
    logic             doe;
    logic [7:0]       dout;
  } exp_t;

  exp_t             exp_q[$];
  logic             probe = 1'b0;
  logic [CFG_W-1:0] cfg_model = '0;
  int               checks = 0;
  int               passes = 0;
  int               txn = 0;

  // Reference model: expected outputs from the current bus and the config last written.
  function automatic exp_t model(input int id);
    exp_t e;
    int   mode, q, page, xb_bank;
    bit   ext, rb;
    mode    = int'(cfg_model[2:0]);
    q       = int'(a[15:14]);
    xb_bank = int'(cfg_model >> 3);
    ext     = 1'b0;
    page    = q;
    if (mode == 2) ext = 1'b1;
    else if (mode == 1 || mode == 3) begin
      ext  = (q == 3);
      page = 3;
    end else if (mode >= 4) begin
      ext  = (q == 1);
      page = mode - 4;
    end
    e.id   = id;
    e.adr  = ext ? ADR_W'(xb_bank * 4 + page) : '0;
    e.dis  = ext;
    e.cs_b = !(ext && !mreq_b);
    e.cfg  = cfg_model;
`ifdef CPC_RAM_READBACK_EN
    rb = !iorq_b && !rd_b && m1_b && !a[15];
`else
    rb = 1'b0;
`endif
    e.doe  = rb;
    e.dout = rb ? (8'hC0 | 8'(cfg_model[5:0])) : 8'h00;
    return e;
  endfunction

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req)
      $display("FAIL %s txn=%0d actual=%h required=%h", nm, id, act, req);
    else
      passes++;
  endtask

  // Monitor: one pop per probe window, compared at the falling edge.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ramcs_b",   e.id, 16'(ramcs_b),   16'(e.cs_b));
        chk("ramdis",    e.id, 16'(ramdis),    16'(e.dis));
        chk("ramadr_hi", e.id, 16'(ramadr_hi), 16'(e.adr));
        chk("cfg",       e.id, 16'(cfg),       16'(e.cfg));
        chk("doe",       e.id, 16'(doe),       16'(e.doe));
        chk("dout",      e.id, 16'(dout),      16'(e.dout));
        $display("txn %0d a=%h cfg=%h cs_b=%b dis=%b adr=%h doe=%b dout=%h",
                 e.id, a, cfg, ramcs_b, ramdis, ramadr_hi, doe, dout);
      end
    end
  end

  task automatic probe_now();
    exp_q.push_back(model(txn));
    txn++;
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic bus_idle();
    iorq_b = 1'b1; mreq_b = 1'b1; wr_b = 1'b1; rd_b = 1'b1; m1_b = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(posedge clk); #3;
    a = addr; d_in = data; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (hold) @(posedge clk);
    #3 bus_idle();
    if (!addr[15] && data[7:6] == 2'b11) cfg_model = {~addr[10:8], data[5:0]};
    repeat (5) @(posedge clk);
  endtask

  task automatic mem_access(input logic [15:0] addr, input logic mreq);
    @(posedge clk); #2;
    a = addr; mreq_b = mreq; rd_b = 1'b0;
    probe_now();
    bus_idle();
  endtask

  task automatic io_read(input logic [15:0] addr, input logic m1);
    @(posedge clk); #2;
    a = addr; iorq_b = 1'b0; rd_b = 1'b0; m1_b = m1;
    probe_now();
    bus_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus_idle();
    a = 16'h0000; d_in = 8'h00; rst = 1'b1;
    repeat (3) @(posedge clk);
    mem_access(16'h4000, 1'b0);            // outputs while reset held
    #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    mem_access(16'h4000, 1'b0);

    // Mode 4 on bank 0
    io_write(16'h7FFF, 8'hC4, 8);
    mem_access(16'h4000, 1'b0);
    mem_access(16'h8000, 1'b0);
    mem_access(16'h4000, 1'b1);

    // Extended bank bits from the inverted port address
    io_write(16'h7EFF, 8'hFF, 8);
    mem_access(16'h4000, 1'b0);

    // Mode 2: all quarters map through
    io_write(16'h7FFF, 8'hC2, 8);
    for (int i = 0; i < 4; i++) mem_access(16'(i * 16'h4000), 1'b0);

    // Non-config writes are ignored
    io_write(16'h7FFF, 8'h84, 8);
    io_write(16'hFFFF, 8'hC4, 8);
    mem_access(16'h4000, 1'b0);

    // A long write captures once even if the data bus changes later
    @(posedge clk); #3;
    a = 16'h7FFF; d_in = 8'hC4; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (8) @(posedge clk);
    #1 d_in = 8'hC1;
    repeat (12) @(posedge clk);
    #3 bus_idle();
    cfg_model = 9'h004;
    repeat (5) @(posedge clk);
    mem_access(16'h4000, 1'b0);

    // Reset mid-write: the write in flight is dropped
    @(posedge clk); #3;
    a = 16'h7FFF; d_in = 8'hC7; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    cfg_model = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (8) @(posedge clk);
    #2 probe_now();
    #3 bus_idle();
    repeat (5) @(posedge clk);
    mem_access(16'hC000, 1'b0);
    io_write(16'h7FFF, 8'hC5, 8);
    mem_access(16'h4000, 1'b0);

    // Readback and interrupt acknowledge
    io_read(16'h7FFF, 1'b1);
    io_read(16'h7FFF, 1'b0);
    io_read(16'hFFFF, 1'b1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ra;
      logic [7:0]  rd;
      int          kind;
      kind = int'($urandom_range(0, 3));
      ra   = 16'($urandom);
      rd   = 8'($urandom);
      if (kind == 0) begin
        if ($urandom_range(0, 3) != 0) ra[15] = 1'b0;
        if ($urandom_range(0, 3) != 0) rd[7:6] = 2'b11;
        io_write(ra, rd, int'($urandom_range(6, 12)));
      end else if (kind == 3) begin
        io_read(ra, ($urandom_range(0, 3) != 0));
      end else begin
        mem_access(ra, ($urandom_range(0, 4) == 0));
      end
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
